// File: rtl/tm1638_pkg.sv
// rtl/tm1638_pkg.sv - TM1638 command constants, FSM state encoding and hex-to-segment helper
package tm1638_pkg;

    localparam logic [7:0] CMD_CFG_BASE  = 8'h80;
    localparam logic [7:0] CMD_ADDR_INC  = 8'h40;
    localparam logic [7:0] CMD_READ_KEYS = 8'h42;
    localparam logic [7:0] CMD_ADDR0     = 8'hC0;

    typedef enum logic [2:0] {
        CFG_ST, ADDR_ST, WRITE_ST, RKEY_ST, WAIT_ST, READ_ST, GAP_ST, NEXT_ST
    } state_t;

    // Segment order g..a in bits 6..0; the dot (bit 7) is left to the caller.
    function automatic logic [7:0] sseg(input logic [3:0] hex);
        case (hex)
            4'h0: sseg = 8'h3F;
            4'h1: sseg = 8'h06;
            4'h2: sseg = 8'h5B;
            4'h3: sseg = 8'h4F;
            4'h4: sseg = 8'h66;
            4'h5: sseg = 8'h6D;
            4'h6: sseg = 8'h7D;
            4'h7: sseg = 8'h07;
            4'h8: sseg = 8'h7F;
            4'h9: sseg = 8'h6F;
            4'hA: sseg = 8'h77;
            4'hB: sseg = 8'h7C;
            4'hC: sseg = 8'h39;
            4'hD: sseg = 8'h5E;
            4'hE: sseg = 8'h79;
            default: sseg = 8'h71;
        endcase
    endfunction

endpackage

// File: rtl/tm1638_bit_engine.sv
// rtl/tm1638_bit_engine.sv - LSB-first byte shifter producing TM1638 CLK and open-drain DIO control
module tm1638_bit_engine #(
    parameter int HALF = 27
) (
    input  logic       sysclock,
    input  logic       sysreset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] wdata,
    input  logic       dio,
    output logic       busy,
    output logic [7:0] rdata,
    output logic       clk,
    output logic       dio_oe_low
);
    logic [7:0] cnt;
    logic [2:0] bit_idx;
    logic       high_phase;
    logic       rd_mode;
    logic [7:0] shreg;

    assign rdata = shreg;

    always_ff @(posedge sysclock) begin
        if (sysreset) begin
            busy       <= 1'b0;
            clk        <= 1'b1;
            dio_oe_low <= 1'b0;
            cnt        <= 8'd0;
            bit_idx    <= 3'd0;
            high_phase <= 1'b0;
            rd_mode    <= 1'b0;
            shreg      <= 8'd0;
        end else if (!busy) begin
            if (start) begin
                busy       <= 1'b1;
                clk        <= 1'b0;
                rd_mode    <= rw;
                shreg      <= wdata;
                dio_oe_low <= !rw && !wdata[0];
                cnt        <= 8'd0;
                bit_idx    <= 3'd0;
                high_phase <= 1'b0;
            end
        end else if (cnt != 8'(HALF - 1)) begin
            cnt <= cnt + 8'd1;
        end else begin
            cnt <= 8'd0;
            if (!high_phase) begin
                // Reads sample on the edge that raises CLK; the device set DIO after the fall.
                high_phase <= 1'b1;
                clk        <= 1'b1;
                if (rd_mode)
                    shreg <= {dio, shreg[7:1]};
            end else if (bit_idx == 3'd7) begin
                busy       <= 1'b0;
                dio_oe_low <= 1'b0;
            end else begin
                high_phase <= 1'b0;
                clk        <= 1'b0;
                bit_idx    <= bit_idx + 3'd1;
                if (!rd_mode) begin
                    shreg      <= {1'b0, shreg[7:1]};
                    dio_oe_low <= !shreg[1];
                end
            end
        end
    end

endmodule

// File: rtl/tm1638_array_driver.sv
// rtl/tm1638_array_driver.sv - round-robin refresh and key scan of several TM1638 boards on one bus
module tm1638_array_driver #(
    parameter int SYSCLK_MHZ     = 27,
    parameter int NUM_DEV        = 2,
    parameter int DEBOUNCE_SCANS = 2
) (
    input  logic                   sysclock,
    input  logic                   sysreset,
    output logic                   device_clk,
    output logic [NUM_DEV-1:0]     device_stb,
    inout  wire                    device_dio,
    input  logic [NUM_DEV*64-1:0]  seg_data,
    input  logic [NUM_DEV*8-1:0]   leds,
    input  logic [2:0]             brightness,
    input  logic                   display_on,
    output logic [NUM_DEV*8-1:0]   buttons,
    output logic                   key_event,
    output logic                   scan_done
);
    import tm1638_pkg::*;

    localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;
    localparam int KEYS  = NUM_DEV * 8;
    localparam logic [IDX_W-1:0] LAST_DEV = IDX_W'(NUM_DEV - 1);
    localparam logic [7:0] HALF_M1 = 8'(SYSCLK_MHZ - 1);

    state_t           state, ret_state;
    logic [1:0]       step;
    logic [4:0]       byte_cnt;
    logic [7:0]       wait_cnt;
    logic [IDX_W-1:0] dev;
    logic [63:0]      frame_seg;
    logic [7:0]       frame_leds;
    logic [KEYS-1:0]  raw;
    logic [2:0]       deb_cnt [KEYS];
    logic [2:0]       cnt_next [KEYS];
    logic [KEYS-1:0]  btn_next;
    logic             any_flip;
    logic             eng_start, eng_rw, eng_busy, dio_oe_low;
    logic [7:0]       eng_wdata, eng_rdata, tx_byte;
    logic [3:0]       wr_idx;
    logic [IDX_W+2:0] key_lo, key_hi;
    logic             unused_rd;

    assign device_dio = dio_oe_low ? 1'b0 : 1'bz;
    assign key_lo     = {dev, 1'b0, byte_cnt[1:0]};
    assign key_hi     = {dev, 1'b1, byte_cnt[1:0]};
    assign unused_rd  = ^{eng_rdata[7:5], eng_rdata[3:1]};

    tm1638_bit_engine #(.HALF(SYSCLK_MHZ)) u_engine (
        .sysclock   (sysclock),
        .sysreset   (sysreset),
        .start      (eng_start),
        .rw         (eng_rw),
        .wdata      (eng_wdata),
        .dio        (device_dio),
        .busy       (eng_busy),
        .rdata      (eng_rdata),
        .clk        (device_clk),
        .dio_oe_low (dio_oe_low)
    );

    // Display RAM alternates segment byte / LED byte per digit.
    always_comb begin
        tx_byte = 8'h00;
        wr_idx  = 4'(byte_cnt - 5'd1);
        case (state)
            CFG_ST:   tx_byte = CMD_CFG_BASE | {4'b0, display_on, brightness};
            ADDR_ST:  tx_byte = CMD_ADDR_INC;
            WRITE_ST: begin
                if (byte_cnt == 5'd0)
                    tx_byte = CMD_ADDR0;
                else if (!wr_idx[0])
                    tx_byte = frame_seg[{wr_idx[3:1], 3'b000} +: 8];
                else
                    tx_byte = {7'b0, frame_leds[wr_idx[3:1]]};
            end
            RKEY_ST:  tx_byte = CMD_READ_KEYS;
            default:  tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        btn_next = buttons;
        any_flip = 1'b0;
        for (int i = 0; i < KEYS; i++) begin
            cnt_next[i] = 3'd0;
            if (raw[i] != buttons[i]) begin
                if (deb_cnt[i] + 3'd1 == 3'(DEBOUNCE_SCANS)) begin
                    btn_next[i] = raw[i];
                    any_flip    = 1'b1;
                end else begin
                    cnt_next[i] = deb_cnt[i] + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge sysclock) begin
        if (sysreset) begin
            state      <= CFG_ST;
            ret_state  <= CFG_ST;
            step       <= 2'd0;
            byte_cnt   <= 5'd0;
            wait_cnt   <= 8'd0;
            dev        <= '0;
            device_stb <= '1;
            eng_start  <= 1'b0;
            eng_rw     <= 1'b0;
            eng_wdata  <= 8'd0;
            frame_seg  <= 64'd0;
            frame_leds <= 8'd0;
            raw        <= '0;
            buttons    <= '0;
            key_event  <= 1'b0;
            scan_done  <= 1'b0;
            for (int i = 0; i < KEYS; i++)
                deb_cnt[i] <= 3'd0;
        end else begin
            eng_start <= 1'b0;
            scan_done <= 1'b0;
            key_event <= 1'b0;
            case (state)
                CFG_ST, ADDR_ST, WRITE_ST, RKEY_ST, READ_ST: begin
                    case (step)
                        2'd0: begin
                            device_stb <= ~(NUM_DEV'(1) << dev);
                            eng_start  <= 1'b1;
                            eng_rw     <= (state == READ_ST);
                            eng_wdata  <= tx_byte;
                            step       <= 2'd1;
                            if (state == WRITE_ST && byte_cnt == 5'd0) begin
                                frame_seg  <= seg_data[{dev, 6'b000000} +: 64];
                                frame_leds <= leds[{dev, 3'b000} +: 8];
                            end
                        end
                        // Engine raises busy one cycle after seeing start; skip that cycle.
                        2'd1: step <= 2'd2;
                        default: if (!eng_busy) begin
                            step <= 2'd0;
                            case (state)
                                CFG_ST: begin
                                    device_stb <= '1;
                                    state      <= GAP_ST;
                                    ret_state  <= ADDR_ST;
                                end
                                ADDR_ST: begin
                                    device_stb <= '1;
                                    state      <= GAP_ST;
                                    ret_state  <= WRITE_ST;
                                end
                                WRITE_ST: begin
                                    if (byte_cnt == 5'd16) begin
                                        device_stb <= '1;
                                        state      <= GAP_ST;
                                        ret_state  <= RKEY_ST;
                                        byte_cnt   <= 5'd0;
                                    end else begin
                                        byte_cnt <= byte_cnt + 5'd1;
                                    end
                                end
                                RKEY_ST: begin
                                    state    <= WAIT_ST;
                                    wait_cnt <= 8'd0;
                                end
                                default: begin
                                    raw[key_lo] <= eng_rdata[0];
                                    raw[key_hi] <= eng_rdata[4];
                                    if (byte_cnt == 5'd3) begin
                                        device_stb <= '1;
                                        state      <= GAP_ST;
                                        ret_state  <= NEXT_ST;
                                        byte_cnt   <= 5'd0;
                                    end else begin
                                        byte_cnt <= byte_cnt + 5'd1;
                                    end
                                end
                            endcase
                        end
                    endcase
                end
                WAIT_ST: begin
                    if (wait_cnt == HALF_M1) begin
                        state    <= READ_ST;
                        wait_cnt <= 8'd0;
                        byte_cnt <= 5'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                GAP_ST: begin
                    if (wait_cnt == HALF_M1) begin
                        state    <= ret_state;
                        wait_cnt <= 8'd0;
                        byte_cnt <= 5'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                NEXT_ST: begin
                    state <= CFG_ST;
                    if (dev == LAST_DEV) begin
                        dev       <= '0;
                        scan_done <= 1'b1;
                        key_event <= any_flip;
                        buttons   <= btn_next;
                        deb_cnt   <= cnt_next;
                    end else begin
                        dev <= dev + 1'b1;
                    end
                end
                default: state <= CFG_ST;
            endcase
        end
    end

endmodule

// File: tb/tb_tm1638_array_driver.sv
// tb/tb_tm1638_array_driver.sv - directed bench with a TM1638 bus model per STB line
module tb_tm1638_array_driver;

    logic         sysclock = 1'b0;
    logic         sysreset;
    logic         device_clk;
    logic [1:0]   device_stb;
    wire          dio_bus;
    logic [127:0] seg_data;
    logic [15:0]  leds;
    logic [2:0]   brightness;
    logic         display_on;
    logic [15:0]  buttons;
    logic         key_event;
    logic         scan_done;

    logic model_low = 1'b0;
    assign dio_bus = model_low ? 1'b0 : 1'bz;
    pullup (dio_bus);

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int ke_count = 0;
    int overlap_err = 0;
    int per_min = 1000;
    int per_max = 0;
    int bcnt [2] = '{0, 0};
    logic [7:0]  blog [2][512];
    logic [31:0] key_data [2] = '{32'h0000_0000, 32'h0010_0000};

    always #5 sysclock = ~sysclock;

    tm1638_array_driver #(
        .SYSCLK_MHZ     (4),
        .NUM_DEV        (2),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .sysclock   (sysclock),
        .sysreset   (sysreset),
        .device_clk (device_clk),
        .device_stb (device_stb),
        .device_dio (dio_bus),
        .seg_data   (seg_data),
        .leds       (leds),
        .brightness (brightness),
        .display_on (display_on),
        .buttons    (buttons),
        .key_event  (key_event),
        .scan_done  (scan_done)
    );

    // Board model: logs written bytes per board, answers 0x42 with key_data.
    initial begin : bfm
        logic       prev_clk;
        logic [1:0] prev_stb;
        logic [7:0] wbyte;
        logic       rmode;
        int act, wbit, rbit, pkt_bytes, last_rise;
        prev_clk = 1'b1; prev_stb = 2'b11; wbyte = 8'h00; rmode = 1'b0;
        act = 0; wbit = 0; rbit = 0; pkt_bytes = 0; last_rise = 0;
        forever begin
            @(negedge sysclock);
            cyc++;
            if ($countones(~device_stb) > 1) overlap_err++;
            if (key_event === 1'b1) ke_count++;
            for (int d = 0; d < 2; d++) begin
                if (prev_stb[d] && !device_stb[d]) begin
                    act = d; wbit = 0; rbit = 0; pkt_bytes = 0; rmode = 1'b0;
                end
                if (!prev_stb[d] && device_stb[d]) begin
                    rmode = 1'b0; model_low = 1'b0;
                end
            end
            if (device_stb != 2'b11) begin
                if (!prev_clk && device_clk && !rmode) begin
                    if (wbit != 0) begin
                        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
                        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
                    end
                    last_rise = cyc;
                    wbyte[wbit] = dio_bus;
                    wbit++;
                    if (wbit == 8) begin
                        if (bcnt[act] < 512) blog[act][bcnt[act]] = wbyte;
                        bcnt[act]++;
                        if (pkt_bytes == 0 && wbyte == 8'h42) rmode = 1'b1;
                        pkt_bytes++;
                        wbit = 0;
                    end
                end
                if (prev_clk && !device_clk && rmode && rbit < 32) begin
                    model_low = !key_data[act][rbit];
                    rbit++;
                end
            end
            prev_clk = device_clk;
            prev_stb = device_stb;
        end
    end

    task automatic wait_scan();
        int n = 0;
        logic ok = 1'b0;
        while (n < 12000 && !ok) begin
            @(negedge sysclock);
            n++;
            if (scan_done === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL scan_timeout got=no scan_done exp=scan_done within 12000 cycles");
        end
    endtask

    task automatic wait_bytes(input int d, input int target);
        int n = 0;
        while (n < 12000 && bcnt[d] < target) begin
            @(negedge sysclock);
            n++;
        end
        if (bcnt[d] < target) begin
            checks++; failures++;
            $display("FAIL byte_timeout got=%0d exp=%0d", bcnt[d], target);
        end
    endtask

    task automatic test_reset();
        sysreset = 1'b1;
        repeat (3) @(negedge sysclock);
        checks++; if (device_stb !== 2'b11) begin failures++; $display("FAIL reset_stb got=%b exp=11", device_stb); end
        checks++; if (device_clk !== 1'b1) begin failures++; $display("FAIL reset_clk got=%b exp=1", device_clk); end
        checks++; if (dio_bus === 1'b0) begin failures++; $display("FAIL reset_dio got=%b exp=released", dio_bus); end
        checks++; if (buttons !== 16'h0000) begin failures++; $display("FAIL reset_buttons got=%h exp=0000", buttons); end
        checks++; if (scan_done !== 1'b0 || key_event !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", scan_done, key_event); end
        sysreset = 1'b0;
    endtask

    task automatic test_first_scan();
        int b0 = bcnt[0];
        int b1 = bcnt[1];
        wait_scan();
        checks++; if (blog[0][b0] !== 8'h8F) begin failures++; $display("FAIL s1_cfg got=%h exp=8f", blog[0][b0]); end
        checks++; if (blog[0][b0+1] !== 8'h40) begin failures++; $display("FAIL s1_addr got=%h exp=40", blog[0][b0+1]); end
        checks++; if (blog[0][b0+2] !== 8'hC0) begin failures++; $display("FAIL s1_addr0 got=%h exp=c0", blog[0][b0+2]); end
        checks++; if (blog[0][b0+3] !== 8'h3F) begin failures++; $display("FAIL s1_seg0 got=%h exp=3f", blog[0][b0+3]); end
        checks++; if (blog[0][b0+4] !== 8'h01) begin failures++; $display("FAIL s1_led0 got=%h exp=01", blog[0][b0+4]); end
        checks++; if (blog[0][b0+5] !== 8'h00) begin failures++; $display("FAIL s1_seg1 got=%h exp=00", blog[0][b0+5]); end
        checks++; if (blog[0][b0+19] !== 8'h42) begin failures++; $display("FAIL s1_rkey got=%h exp=42", blog[0][b0+19]); end
        checks++; if (bcnt[0] - b0 !== 20) begin failures++; $display("FAIL s1_count got=%0d exp=20", bcnt[0] - b0); end
        checks++; if (blog[1][b1] !== 8'h8F) begin failures++; $display("FAIL s1_b1_cfg got=%h exp=8f", blog[1][b1]); end
        checks++; if (per_min !== 8 || per_max !== 8) begin failures++; $display("FAIL clk_period got=%0d..%0d exp=8..8", per_min, per_max); end
        checks++; if (overlap_err !== 0) begin failures++; $display("FAIL stb_overlap got=%0d exp=0", overlap_err); end
        checks++; if (buttons[14] !== 1'b0 || key_event !== 1'b0) begin failures++; $display("FAIL s1_key got=%b/%b exp=0/0", buttons[14], key_event); end
    endtask

    task automatic test_debounce();
        wait_scan();
        checks++; if (key_event !== 1'b1) begin failures++; $display("FAIL s2_event got=%b exp=1", key_event); end
        checks++; if (buttons !== 16'h4000) begin failures++; $display("FAIL s2_buttons got=%h exp=4000", buttons); end
        wait_scan();
        checks++; if (key_event !== 1'b0) begin failures++; $display("FAIL s3_event got=%b exp=0", key_event); end
        checks++; if (ke_count !== 1) begin failures++; $display("FAIL s3_event_count got=%0d exp=1", ke_count); end
    endtask

    task automatic test_glitch();
        key_data[0] = 32'h0000_0001;
        wait_scan();
        checks++; if (buttons !== 16'h4000 || key_event !== 1'b0) begin failures++; $display("FAIL glitch_scan got=%h/%b exp=4000/0", buttons, key_event); end
        key_data[0] = 32'h0000_0000;
        wait_scan();
        checks++; if (buttons[0] !== 1'b0 || key_event !== 1'b0) begin failures++; $display("FAIL glitch_after got=%b/%b exp=0/0", buttons[0], key_event); end
        checks++; if (ke_count !== 1) begin failures++; $display("FAIL glitch_count got=%0d exp=1", ke_count); end
    endtask

    task automatic test_snapshot();
        int b0 = bcnt[0];
        int b1 = bcnt[1];
        wait_bytes(0, b0 + 8);
        seg_data[7:0] = 8'h06;
        brightness = 3'd3;
        display_on = 1'b0;
        wait_scan();
        checks++; if (blog[0][b0+3] !== 8'h3F) begin failures++; $display("FAIL tear_seg got=%h exp=3f", blog[0][b0+3]); end
        checks++; if (blog[0][b0] !== 8'h8F) begin failures++; $display("FAIL tear_cfg got=%h exp=8f", blog[0][b0]); end
        checks++; if (blog[1][b1] !== 8'h83) begin failures++; $display("FAIL next_cfg_b1 got=%h exp=83", blog[1][b1]); end
        b0 = bcnt[0];
        wait_scan();
        checks++; if (blog[0][b0+3] !== 8'h06) begin failures++; $display("FAIL new_seg got=%h exp=06", blog[0][b0+3]); end
        checks++; if (blog[0][b0] !== 8'h83) begin failures++; $display("FAIL new_cfg got=%h exp=83", blog[0][b0]); end
        brightness = 3'd7;
        display_on = 1'b1;
    endtask

    task automatic test_reset_mid_byte();
        int b0;
        int b1 = bcnt[1];
        wait_bytes(1, b1 + 5);
        repeat (3) @(negedge sysclock);
        sysreset = 1'b1;
        @(negedge sysclock);
        checks++; if (device_stb !== 2'b11) begin failures++; $display("FAIL mid_stb got=%b exp=11", device_stb); end
        checks++; if (device_clk !== 1'b1) begin failures++; $display("FAIL mid_clk got=%b exp=1", device_clk); end
        checks++; if (dio_bus === 1'b0) begin failures++; $display("FAIL mid_dio got=%b exp=released", dio_bus); end
        checks++; if (buttons !== 16'h0000) begin failures++; $display("FAIL mid_buttons got=%h exp=0000", buttons); end
        sysreset = 1'b0;
        b0 = bcnt[0];
        wait_scan();
        checks++; if (blog[0][b0] !== 8'h8F) begin failures++; $display("FAIL restart_cfg got=%h exp=8f", blog[0][b0]); end
        checks++; if (blog[0][b0+1] !== 8'h40) begin failures++; $display("FAIL restart_addr got=%h exp=40", blog[0][b0+1]); end
        checks++; if (overlap_err !== 0) begin failures++; $display("FAIL final_overlap got=%0d exp=0", overlap_err); end
    endtask

    initial begin
        sysreset = 1'b1;
        seg_data = '0;
        seg_data[7:0] = 8'h3F;
        leds = 16'h0001;
        brightness = 3'd7;
        display_on = 1'b1;
        test_reset();
        test_first_scan();
        test_debounce();
        test_glitch();
        test_snapshot();
        test_reset_mid_byte();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
